vector_op_engine: RTL and testbench

- Parametrised Avalon-MM vector accelerator for the Nios-side register interface.
- Holds two operand vectors A and B plus control/status/result registers.
- On a software start it walks LEN elements, one per clock, and reduces them by the selected operation (SUM, ADD, DOT, MAX).
- Completion is signalled by a sticky status bit and an optional maskable interrupt.

---
 rtl/vector_op_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_vector_op_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_op_engine.sv
`timescale 1ns/1ps
// Avalon-MM register-mapped vector reduction engine (SUM, ADD, DOT, MAX over LEN elements).
// Define VECTOR_OP_SATURATE_EN to clamp the accumulator on overflow and report OVF.
module vector_op_engine #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned VEC_LEN       = 8,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] slave_address,
   input  logic                     slave_read,
   output logic [31:0]              slave_readdata,
   input  logic                     slave_write,
   input  logic [31:0]              slave_writedata,
   output logic                     slave_waitrequest,
   output logic                     done_irq
);

   localparam int unsigned IdxW   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int unsigned ABase  = 4;
   localparam int unsigned BBase  = 4 + VEC_LEN;
   localparam int unsigned MapEnd = 4 + 2 * VEC_LEN;

   localparam logic [1:0] OpSum = 2'b00;
   localparam logic [1:0] OpAdd = 2'b01;
   localparam logic [1:0] OpDot = 2'b10;

   typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d, run_op_q, run_op_d;
   logic                  ie_q, ie_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
   logic                  sat_q, sat_d, irq_q, irq_d;
   logic [DATA_WIDTH-1:0] result_q, result_d, len_q, len_d, acc_q, acc_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [DATA_WIDTH-1:0] a_q [VEC_LEN];
   logic [DATA_WIDTH-1:0] a_d [VEC_LEN];
   logic [DATA_WIDTH-1:0] b_q [VEC_LEN];
   logic [DATA_WIDTH-1:0] b_d [VEC_LEN];

   int unsigned     addr;
   logic            sel_ctrl, sel_status, sel_result, sel_len, sel_a, sel_b;
   logic            busy, wr_en, start, abort;
   logic [IdxW-1:0] a_sel, b_sel;

   assign addr       = 32'(slave_address);
   assign sel_ctrl   = (addr == 0);
   assign sel_status = (addr == 1);
   assign sel_result = (addr == 2);
   assign sel_len    = (addr == 3);
   assign sel_a      = (addr >= ABase) && (addr < BBase);
   assign sel_b      = (addr >= BBase) && (addr < MapEnd);
   assign a_sel      = IdxW'(addr - ABase);
   assign b_sel      = IdxW'(addr - BBase);
   assign busy       = (state_q != StIdle);

   // Only operand/length writes are held off while a run is reading them.
   assign slave_waitrequest = slave_write & busy & (sel_len | sel_a | sel_b);
   assign wr_en             = slave_write & ~slave_waitrequest;
   assign done_irq          = irq_q;

   always_comb begin
      slave_readdata = '0;
      if (slave_read) begin
         if (sel_ctrl) begin
            slave_readdata = {27'b0, 1'b0, ie_q, op_q, 1'b0};
         end else if (sel_status) begin
            slave_readdata = {28'b0, ovf_q, err_q, done_q, busy};
         end else if (sel_result) begin
            slave_readdata = 32'(result_q);
         end else if (sel_len) begin
            slave_readdata = 32'(len_q);
         end else if (sel_a) begin
            slave_readdata = 32'(a_q[a_sel]);
         end else if (sel_b) begin
            slave_readdata = 32'(b_q[b_sel]);
         end
      end
   end

   logic [DATA_WIDTH-1:0]   elem_a, elem_b, step_val;
   logic [DATA_WIDTH+1:0]   sum_ext;
   logic [DATA_WIDTH:0]     dot_ext;
   logic [2*DATA_WIDTH-1:0] prod;
   logic                    step_ovf;

   always_comb begin
      elem_a  = a_q[idx_q];
      elem_b  = b_q[idx_q];
      prod    = {{DATA_WIDTH{1'b0}}, elem_a} * {{DATA_WIDTH{1'b0}}, elem_b};
      sum_ext = {2'b00, acc_q} + {2'b00, elem_a}
              + ((run_op_q == OpAdd) ? {2'b00, elem_b} : '0);
      dot_ext = {1'b0, acc_q} + {1'b0, prod[DATA_WIDTH-1:0]};
      case (run_op_q)
         OpSum, OpAdd: begin
            step_val = sum_ext[DATA_WIDTH-1:0];
            step_ovf = |sum_ext[DATA_WIDTH+1:DATA_WIDTH];
         end
         OpDot: begin
            step_val = dot_ext[DATA_WIDTH-1:0];
            step_ovf = dot_ext[DATA_WIDTH] | (|prod[2*DATA_WIDTH-1:DATA_WIDTH]);
         end
         default: begin
            step_val = (elem_a > acc_q) ? elem_a : acc_q;
            step_ovf = 1'b0;
         end
      endcase
   end

`ifndef VECTOR_OP_SATURATE_EN
   logic unused_sat;
   assign unused_sat = sat_q ^ step_ovf;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      run_op_d = run_op_q;
      ie_d     = ie_q;
      done_d   = done_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      sat_d    = sat_q;
      result_d = result_q;
      len_d    = len_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      irq_d    = ie_q & done_q;
      start    = wr_en & sel_ctrl & slave_writedata[0];
      abort    = wr_en & sel_ctrl & slave_writedata[4];

      if (wr_en) begin
         if (sel_ctrl) begin
            op_d = slave_writedata[2:1];
            ie_d = slave_writedata[3];
         end
         if (sel_status) begin
            if (slave_writedata[1]) done_d = 1'b0;
            if (slave_writedata[2]) err_d = 1'b0;
            if (slave_writedata[3]) ovf_d = 1'b0;
         end
         if (sel_len) len_d = slave_writedata[DATA_WIDTH-1:0];
         if (sel_a) a_d[a_sel] = slave_writedata[DATA_WIDTH-1:0];
         if (sel_b) b_d[b_sel] = slave_writedata[DATA_WIDTH-1:0];
      end

      // Hardware status sets come last so they win over a same-cycle W1C.
      case (state_q)
         StIdle: begin
            if (start) begin
               if ((len_q != '0) && (32'(len_q) <= VEC_LEN)) begin
                  state_d  = StRun;
                  run_op_d = slave_writedata[2:1];
                  idx_d    = '0;
                  acc_d    = '0;
                  sat_d    = 1'b0;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
`ifdef VECTOR_OP_SATURATE_EN
               if (sat_q || step_ovf) begin
                  acc_d = '1;
                  sat_d = 1'b1;
               end else begin
                  acc_d = step_val;
               end
`else
               acc_d = step_val;
`endif
               idx_d = idx_q + IdxW'(1);
               if (idx_q == IdxW'(len_q - DATA_WIDTH'(1))) state_d = StFinish;
            end
         end
         StFinish: begin
            result_d = acc_q;
            done_d   = 1'b1;
`ifdef VECTOR_OP_SATURATE_EN
            if (sat_q) ovf_d = 1'b1;
`endif
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= '0;
         run_op_q <= '0;
         ie_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
         irq_q    <= 1'b0;
         result_q <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         a_q      <= '{default: '0};
         b_q      <= '{default: '0};
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         run_op_q <= run_op_d;
         ie_q     <= ie_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
         irq_q    <= irq_d;
         result_q <= result_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

endmodule

// File: tb/tb_vector_op_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for vector_op_engine: reads push expectations, a negedge monitor compares.
module tb_vector_op_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  slave_address;
   logic        slave_read, slave_write;
   logic [31:0] slave_readdata, slave_writedata;
   logic        slave_waitrequest, done_irq;

   int checks = 0;
   int errors = 0;

   string       name_q[$];
   logic [31:0] data_q[$];
   bit          ci_q[$];
   bit          ei_q[$];

   logic [31:0] a_m [8];
   logic [31:0] b_m [8];
   logic [31:0] result_m;
   int          len_m;

   vector_op_engine #(
      .DATA_WIDTH   (32),
      .VEC_LEN      (8),
      .ADDRESS_WIDTH(5)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .slave_address    (slave_address),
      .slave_read       (slave_read),
      .slave_readdata   (slave_readdata),
      .slave_write      (slave_write),
      .slave_writedata  (slave_writedata),
      .slave_waitrequest(slave_waitrequest),
      .done_irq         (done_irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (slave_read) begin
         string       n;
         logic [31:0] d;
         bit          ci, ei;
         if (name_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: addr %0d got %h required none", slave_address,
                     slave_readdata);
         end else begin
            n  = name_q.pop_front();
            d  = data_q.pop_front();
            ci = ci_q.pop_front();
            ei = ei_q.pop_front();
            checks++;
            if (slave_readdata !== d) begin
               errors++;
               $display("FAIL %s: got %h required %h", n, slave_readdata, d);
            end
            if (ci) begin
               checks++;
               if (done_irq !== ei) begin
                  errors++;
                  $display("FAIL %s_irq: got %b required %b", n, done_irq, ei);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic wr_stall(input int addr, input logic [31:0] data, output int stalls);
      slave_address   = 5'(addr);
      slave_writedata = data;
      slave_write     = 1'b1;
      stalls          = 0;
      @(negedge clk);
      while (slave_waitrequest && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      if (slave_waitrequest) begin
         checks++;
         errors++;
         $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", addr, stalls);
      end
      @(posedge clk);
      #1;
      slave_write = 1'b0;
   endtask

   task automatic wr(input int addr, input logic [31:0] data);
      int s;
      wr_stall(addr, data, s);
   endtask

   task automatic rd(input int addr, input logic [31:0] exp, input string name, input bit ci,
                     input bit ei);
      name_q.push_back(name);
      data_q.push_back(exp);
      ci_q.push_back(ci);
      ei_q.push_back(ei);
      slave_address = 5'(addr);
      slave_read    = 1'b1;
      @(posedge clk);
      #1;
      slave_read = 1'b0;
   endtask

   task automatic wr_len(input int n);
      wr(3, 32'(n));
      len_m = n;
   endtask

   task automatic wr_a(input int i, input logic [31:0] v);
      wr(4 + i, v);
      a_m[i] = v;
   endtask

   task automatic wr_b(input int i, input logic [31:0] v);
      wr(12 + i, v);
      b_m[i] = v;
   endtask

   // Straight loop over the elements with wide arithmetic; overflow is anything past 32 bits.
   function automatic void model_run(input logic [1:0] op, input int len, output logic [31:0] res,
                                     output bit ovf);
      longint unsigned acc, p;
      bit              o;
      acc = 0;
      o   = 1'b0;
      for (int i = 0; i < len; i++) begin
         bit step;
         step = 1'b0;
         case (op)
            2'd0: acc = acc + 64'(a_m[i]);
            2'd1: acc = acc + 64'(a_m[i]) + 64'(b_m[i]);
            2'd2: begin
               p = 64'(a_m[i]) * 64'(b_m[i]);
               if (p > 64'hFFFF_FFFF) step = 1'b1;
               acc = acc + (p & 64'hFFFF_FFFF);
            end
            default: if (64'(a_m[i]) > acc) acc = 64'(a_m[i]);
         endcase
         if (acc > 64'hFFFF_FFFF) step = 1'b1;
`ifdef VECTOR_OP_SATURATE_EN
         if (step) o = 1'b1;
         if (o) acc = 64'hFFFF_FFFF;
`else
         acc = acc & 64'hFFFF_FFFF;
`endif
      end
      res = acc[31:0];
      ovf = o;
   endfunction

   function automatic logic [31:0] rnd_elem();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'($urandom_range(0, 5000));
   endfunction

   task automatic run_and_check(input logic [1:0] op, input bit ie, input string tag);
      logic [31:0] res, st;
      bit          ovf;
      model_run(op, len_m, res, ovf);
      st = {28'b0, ovf, 3'b010};
      wr(1, 32'hE);
      wr(0, {28'b0, ie, op, 1'b1});
      for (int k = 0; k <= len_m; k++) rd(1, 32'h1, $sformatf("%s_busy%0d", tag, k), 1'b1, 1'b0);
      rd(1, st, $sformatf("%s_done", tag), 1'b1, 1'b0);
      rd(1, st, $sformatf("%s_irq", tag), 1'b1, ie);
      rd(2, res, $sformatf("%s_result", tag), 1'b0, 1'b0);
      result_m = res;
   endtask

   initial begin
      int          stalls;
      logic [31:0] res;
      bit          ovf;

      rst             = 1'b1;
      slave_read      = 1'b0;
      slave_write     = 1'b0;
      slave_address   = '0;
      slave_writedata = '0;
      a_m             = '{default: '0};
      b_m             = '{default: '0};
      result_m        = '0;
      len_m           = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_waitrequest", 32'(slave_waitrequest), 32'h0);
      check("rst_irq", 32'(done_irq), 32'h0);
      check("rst_readdata_idle", slave_readdata, 32'h0);
      for (int i = 0; i < 20; i++) rd(i, 32'h0, $sformatf("rst_reg%0d", i), 1'b1, 1'b0);

      // SUM of 1..4 with interrupt, then clear DONE to drop the interrupt
      wr_len(4);
      for (int i = 0; i < 4; i++) wr_a(i, 32'(i + 1));
      run_and_check(2'd0, 1'b1, "sum4");
      slave_address = 5'd2;
      #1;
      check("readdata_no_read", slave_readdata, 32'h0);
      wr(1, 32'h2);
      rd(1, 32'h0, "w1c_status", 1'b0, 1'b0);
      rd(1, 32'h0, "w1c_irq_low", 1'b1, 1'b0);

      wr_len(3);
      for (int i = 0; i < 3; i++) begin
         wr_a(i, 32'(i + 2));
         wr_b(i, 32'(i + 5));
      end
      run_and_check(2'd2, 1'b0, "dot3");
      run_and_check(2'd1, 1'b0, "add3");
      run_and_check(2'd3, 1'b0, "max3");

      wr_len(2);
      wr_a(0, 32'hFFFF_FFFF);
      wr_a(1, 32'h2);
      run_and_check(2'd0, 1'b0, "ovf_sum");

      // Bad lengths: ERR and DONE, never busy, result untouched
      wr_len(0);
      wr(1, 32'hE);
      wr(0, 32'h1);
      rd(1, 32'h6, "err_len0_status", 1'b0, 1'b0);
      rd(2, result_m, "err_len0_result", 1'b0, 1'b0);
      wr_len(9);
      wr(1, 32'hE);
      wr(0, 32'h1);
      rd(1, 32'h6, "err_len9_status", 1'b0, 1'b0);
      rd(2, result_m, "err_len9_result", 1'b0, 1'b0);

      // Operand write during a run stalls until idle; the run sees the old value
      wr_len(8);
      for (int i = 0; i < 8; i++) wr_a(i, rnd_elem());
      model_run(2'd0, 8, res, ovf);
      wr(1, 32'hE);
      wr(0, 32'h1);
      wr_stall(4, 32'h55, stalls);
      check("stall_cycles", 32'(stalls), 32'd9);
      a_m[0] = 32'h55;
      rd(1, {28'b0, ovf, 3'b010}, "stall_status", 1'b0, 1'b0);
      rd(2, res, "stall_result", 1'b0, 1'b0);
      rd(4, 32'h55, "stall_a0", 1'b0, 1'b0);
      result_m = res;

      // Abort on the third run cycle
      wr(1, 32'hE);
      wr(0, 32'h1);
      rd(1, 32'h1, "abort_busy0", 1'b0, 1'b0);
      rd(1, 32'h1, "abort_busy1", 1'b0, 1'b0);
      wr(0, 32'h10);
      rd(1, 32'h0, "abort_status", 1'b0, 1'b0);
      rd(2, result_m, "abort_result", 1'b1, 1'b0);

      // DONE clear on the finishing edge loses to the hardware set
      wr_len(2);
      model_run(2'd0, 2, res, ovf);
      wr(1, 32'hE);
      wr(0, 32'h1);
      rd(1, 32'h1, "fin_w1c_busy0", 1'b0, 1'b0);
      rd(1, 32'h1, "fin_w1c_busy1", 1'b0, 1'b0);
      wr(1, 32'h2);
      rd(1, {28'b0, ovf, 3'b010}, "fin_w1c_status", 1'b0, 1'b0);
      rd(2, res, "fin_w1c_result", 1'b0, 1'b0);
      result_m = res;

      // START on the finishing edge is ignored
      wr(1, 32'hE);
      wr(0, 32'h1);
      rd(1, 32'h1, "fin_start_busy0", 1'b0, 1'b0);
      rd(1, 32'h1, "fin_start_busy1", 1'b0, 1'b0);
      wr(0, 32'h1);
      rd(1, {28'b0, ovf, 3'b010}, "fin_start_status", 1'b0, 1'b0);
      rd(1, {28'b0, ovf, 3'b010}, "fin_start_idle", 1'b0, 1'b0);

      // START with a new OP while busy: OP register changes, running op does not
      wr_len(4);
      for (int i = 0; i < 4; i++) begin
         wr_a(i, rnd_elem());
         wr_b(i, rnd_elem());
      end
      model_run(2'd0, 4, res, ovf);
      wr(1, 32'hE);
      wr(0, 32'h1);
      wr(0, 32'h5);
      for (int k = 0; k < 4; k++) rd(1, 32'h1, $sformatf("busy_start_busy%0d", k), 1'b0, 1'b0);
      rd(1, {28'b0, ovf, 3'b010}, "busy_start_status", 1'b0, 1'b0);
      rd(2, res, "busy_start_result", 1'b0, 1'b0);
      rd(0, 32'h4, "ctrl_readback", 1'b0, 1'b0);
      result_m = res;

      for (int t = 0; t < 24; t++) begin
         int n;
         n = $urandom_range(1, 8);
         wr_len(n);
         for (int i = 0; i < n; i++) begin
            wr_a(i, rnd_elem());
            wr_b(i, rnd_elem());
         end
         run_and_check(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $sformatf("rnd%0d", t));
      end

      wr(21, 32'hDEAD_BEEF);
      rd(21, 32'h0, "unmapped21", 1'b0, 1'b0);
      rd(31, 32'h0, "unmapped31", 1'b0, 1'b0);

      // Reset in the middle of a run
      wr_len(8);
      wr(1, 32'hE);
      wr(0, 32'h9);
      rd(1, 32'h1, "midrst_busy", 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(1, 32'h0, "midrst_status", 1'b1, 1'b0);
      rd(2, 32'h0, "midrst_result", 1'b0, 1'b0);
      rd(3, 32'h0, "midrst_len", 1'b0, 1'b0);
      rd(0, 32'h0, "midrst_ctrl", 1'b0, 1'b0);
      rd(4, 32'h0, "midrst_a0", 1'b1, 1'b0);

      repeat (3) @(posedge clk);
      check("scoreboard_drain", 32'(name_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
